stack_calc_top: RTL and testbench

//  Board-level 8-bit RPN stack calculator: 4 pushbuttons select a command, 8 switches supply operand.

---
 rtl/stack_calc_pkg.sv | 50 +++++
 rtl/stack_calc_top_btn_debounce.sv | 66 ++++++
 rtl/stack_calc_top.sv | 194 +++++++++++++++++++
 tb/tb_stack_calc_top.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stack_calc_pkg.sv
// stack_calc_pkg
// Shared definitions for the RPN stack calculator: button command codes,
// stack geometry, FSM state type and the hex-to-7-segment table.
package stack_calc_pkg;

  localparam int         STACK_DEPTH = 128;
  localparam logic [6:0] SPR_EMPTY   = 7'h7F;
  localparam logic [6:0] SPR_FULL    = 7'h00;

  // Command codes, bit order {Left, Right, Down, Up}
  localparam logic [3:0] CMD_PUSH    = 4'b0001;
  localparam logic [3:0] CMD_POP     = 4'b0010;
  localparam logic [3:0] CMD_ADD     = 4'b0101;
  localparam logic [3:0] CMD_SUB     = 4'b0110;
  localparam logic [3:0] CMD_CLEAR   = 4'b1010;
  localparam logic [3:0] CMD_DAR_TOP = 4'b1001;
  localparam logic [3:0] CMD_DAR_INC = 4'b1101;
  localparam logic [3:0] CMD_DAR_DEC = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC
  } calc_state_t;

  // Active-low segments, g..a in [6:0]
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/stack_calc_top_btn_debounce.sv
// btn_debounce
// Synchronises a 4-bit raw button vector, filters it, and emits a one-cycle
// strobe one cycle after the filtered code goes from zero to nonzero.
// Build option: STACK_CALC_DEBOUNCE_EN defined -> the synchronised code must
// be stable for DEBOUNCE_CYCLES cycles before it is accepted; undefined ->
// the synchronised code is accepted directly.
// Ports:
//   clk     in  1  system clock
//   rst     in  1  asynchronous active-high reset
//   raw     in  4  raw buttons {Left, Right, Down, Up}, asynchronous to clk
//   code    out 4  filtered button code
//   strobe  out 1  single-cycle command trigger
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw,
  output logic [3:0] code,
  output logic       strobe
);

`ifdef STACK_CALC_DEBOUNCE_EN
  localparam bit DEBOUNCE_ON = 1'b1;
`else
  localparam bit DEBOUNCE_ON = 1'b0;
`endif

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    sync1_reg, sync2_reg, prev_reg;
  logic [3:0]    code_reg, code_d_reg;
  logic [CW-1:0] cnt_reg;
  logic          strobe_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      prev_reg   <= '0;
      code_reg   <= '0;
      code_d_reg <= '0;
      cnt_reg    <= '0;
      strobe_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      if (!DEBOUNCE_ON) begin
        code_reg <= sync2_reg;
      end else if (sync2_reg != prev_reg) begin
        cnt_reg <= '0;                       // any change restarts the window
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        code_reg <= sync2_reg;               // counter parks here while stable
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      code_d_reg <= code_reg;
      strobe_reg <= (code_reg != 4'b0000) && (code_d_reg == 4'b0000);
    end
  end

  assign code   = code_reg;
  assign strobe = strobe_reg;

endmodule

// File: rtl/stack_calc_top.sv
// stack_calc_top
// Board-level 8-bit RPN stack calculator. Buttons select a command, switches
// supply the operand. A 128x8 stack RAM grows downward from 0x7F; SPR points
// at the next free slot, DAR selects the displayed entry, DVR holds its value.
// DAR/DVR are shown on a 4-digit multiplexed 7-segment display, stack-empty
// and DAR on the LEDs.
// Build option: STACK_CALC_DEBOUNCE_EN (see btn_debounce).
// Ports:
//   CLK                    in  1  system clock
//   RST                    in  1  asynchronous active-high reset
//   Button*_unfiltered     in  1  raw pushbuttons Up/Down/Right/Left
//   SWITCH                 in  8  push operand
//   LED                    out 8  [7]=stack empty, [6:0]=DAR
//   mainAnode0..3          out 1  digit enables, active-low, anode0 rightmost
//   mainTOPsevenSeg        out 7  segments g..a, active-low
module stack_calc_top
  import stack_calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 32,
  parameter int REFRESH_BITS    = 17
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ButtonUp_unfiltered,
  input  logic       ButtonDown_unfiltered,
  input  logic       ButtonRight_unfiltered,
  input  logic       ButtonLeft_unfiltered,
  input  logic [7:0] SWITCH,
  output logic [7:0] LED,
  output logic       mainAnode0,
  output logic       mainAnode1,
  output logic       mainAnode2,
  output logic       mainAnode3,
  output logic [6:0] mainTOPsevenSeg
);

  logic [3:0] btn_code;
  logic       btn_strobe;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (CLK),
    .rst   (RST),
    .raw   ({ButtonLeft_unfiltered, ButtonRight_unfiltered,
             ButtonDown_unfiltered, ButtonUp_unfiltered}),
    .code  (btn_code),
    .strobe(btn_strobe)
  );

  // ---------------- stack state ----------------
  logic [7:0]  mem [0:STACK_DEPTH-1];
  logic [6:0]  spr_reg, spr_next;
  logic [6:0]  dar_reg, dar_next;
  logic [7:0]  dvr_reg;
  logic [3:0]  cmd_reg;
  logic [7:0]  a_reg, b_reg;
  calc_state_t state_reg, state_next;

  logic        we_a, we_b, dvr_clear;
  logic [6:0]  addr_a, addr_b;
  logic [7:0]  data_a;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state plus the EXEC-cycle write/update controls
  always_comb begin
    state_next = state_reg;
    we_a       = 1'b0;
    we_b       = 1'b0;
    addr_a     = spr_reg;
    addr_b     = spr_reg + 7'd1;
    data_a     = 8'h00;
    spr_next   = spr_reg;
    dar_next   = dar_reg;
    dvr_clear  = 1'b0;
    case (state_reg)
      ST_IDLE: if (btn_strobe) state_next = ST_READ;
      ST_READ: state_next = ST_EXEC;
      ST_EXEC: begin
        state_next = ST_IDLE;
        case (cmd_reg)
          CMD_PUSH: if (spr_reg != SPR_FULL) begin
            we_a     = 1'b1;
            addr_a   = spr_reg;
            data_a   = SWITCH;
            spr_next = spr_reg - 7'd1;
            dar_next = spr_reg;
          end
          CMD_POP: if (spr_reg != SPR_EMPTY) begin
            we_a     = 1'b1;
            addr_a   = spr_reg + 7'd1;
            spr_next = spr_reg + 7'd1;
            dar_next = spr_reg + 7'd2;         // wraps to 0x00 when emptied
          end
          CMD_ADD, CMD_SUB: if (spr_reg <= 7'h7D) begin
            // result lands in the lower operand slot, upper slot is zeroed
            we_a     = 1'b1;
            addr_a   = spr_reg + 7'd2;
            data_a   = (cmd_reg == CMD_ADD) ? (a_reg + b_reg) : (a_reg - b_reg);
            we_b     = 1'b1;
            addr_b   = spr_reg + 7'd1;
            spr_next = spr_reg + 7'd1;
            dar_next = spr_reg + 7'd2;
          end
          CMD_CLEAR: begin
            spr_next  = SPR_EMPTY;
            dar_next  = 7'h00;
            dvr_clear = 1'b1;
          end
          CMD_DAR_TOP: dar_next = spr_reg + 7'd1;
          CMD_DAR_INC: dar_next = dar_reg + 7'd1;
          CMD_DAR_DEC: dar_next = dar_reg - 7'd1;
          default: ;
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= 8'h00;
      spr_reg <= SPR_EMPTY;
      dar_reg <= 7'h00;
      dvr_reg <= 8'h00;
      cmd_reg <= 4'h0;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
    end else begin
      if (state_reg == ST_IDLE && btn_strobe) cmd_reg <= btn_code;
      if (state_reg == ST_READ) begin
        a_reg <= mem[spr_reg + 7'd2];
        b_reg <= mem[spr_reg + 7'd1];
      end
      if (we_a) mem[addr_a] <= data_a;
      if (we_b) mem[addr_b] <= 8'h00;
      spr_reg <= spr_next;
      dar_reg <= dar_next;
      dvr_reg <= dvr_clear ? 8'h00 : mem[dar_reg];
    end
  end

  assign LED = {spr_reg == SPR_EMPTY, dar_reg};

  // ---------------- display multiplexer ----------------
  logic [REFRESH_BITS-1:0] refresh_reg;
  logic [1:0]              digit_sel;
  logic [3:0]              digit_nib;
  logic                    refresh_step;
  logic                    scan_on_reg;
  logic [3:0]              anode_reg;
  logic [6:0]              seg_reg;

  assign digit_sel    = refresh_reg[REFRESH_BITS-1 -: 2];
  assign refresh_step = &refresh_reg[REFRESH_BITS-3:0];

  always_comb begin
    digit_nib = dvr_reg[3:0];
    case (digit_sel)
      2'd0: digit_nib = dvr_reg[3:0];
      2'd1: digit_nib = dvr_reg[7:4];
      2'd2: digit_nib = dar_reg[3:0];
      default: digit_nib = {1'b0, dar_reg[6:4]};
    endcase
  end

  // Display stays blank until the first digit step, then tracks every cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      refresh_reg <= '0;
      scan_on_reg <= 1'b0;
      anode_reg   <= 4'hF;
      seg_reg     <= 7'h7F;
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
      if (refresh_step) scan_on_reg <= 1'b1;
      if (refresh_step || scan_on_reg) begin
        anode_reg <= ~(4'b0001 << digit_sel);
        seg_reg   <= hex_to_seg(digit_nib);
      end
    end
  end

  assign mainAnode0      = anode_reg[0];
  assign mainAnode1      = anode_reg[1];
  assign mainAnode2      = anode_reg[2];
  assign mainAnode3      = anode_reg[3];
  assign mainTOPsevenSeg = seg_reg;

endmodule

// File: tb/tb_stack_calc_top.sv
module tb_stack_calc_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buttons = 4'h0;   // {Left, Right, Down, Up}
  logic [7:0] switch_val = 8'h00;
  logic [7:0] led;
  logic       an0, an1, an2, an3;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stack_calc_top #(
    .DEBOUNCE_CYCLES(32),
    .REFRESH_BITS   (6)
  ) dut (
    .CLK                   (clk),
    .RST                   (rst),
    .ButtonUp_unfiltered   (buttons[0]),
    .ButtonDown_unfiltered (buttons[1]),
    .ButtonRight_unfiltered(buttons[2]),
    .ButtonLeft_unfiltered (buttons[3]),
    .SWITCH                (switch_val),
    .LED                   (led),
    .mainAnode0            (an0),
    .mainAnode1            (an1),
    .mainAnode2            (an2),
    .mainAnode3            (an3),
    .mainTOPsevenSeg       (seg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Active-low g..a patterns of a standard hex display
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic press(input logic [3:0] b, input logic [7:0] sw, input string name);
    switch_val = sw;
    buttons    = b;
    repeat (100) @(posedge clk);
    buttons = 4'h0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    $display("cmd %-8s code=%b sw=0x%02h led=0x%02h", name, b, sw, led);
  endtask

  task automatic expect_state(input string tag, input logic [6:0] spr,
                              input logic [7:0] led_exp, input logic [7:0] dvr);
    check({tag, "_spr"}, dut.spr_reg, spr);
    check({tag, "_led"}, led, led_exp);
    check({tag, "_dvr"}, dut.dvr_reg, dvr);
  endtask

  // Scan two full refresh periods and compare every digit against DAR/DVR
  task automatic check_display(input string tag, input logic [6:0] dar, input logic [7:0] dvr);
    logic [6:0] cap [4];
    logic [3:0] an;
    int bad = 0;
    for (int d = 0; d < 4; d++) cap[d] = 7'h7F;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      an = {an3, an2, an1, an0};
      if ($countones(~an) != 1) bad++;
      for (int d = 0; d < 4; d++) if (!an[d]) cap[d] = seg;
    end
    check({tag, "_onehot"}, bad, 0);
    check({tag, "_dig3"}, cap[3], seg_of({1'b0, dar[6:4]}));
    check({tag, "_dig2"}, cap[2], seg_of(dar[3:0]));
    check({tag, "_dig1"}, cap[1], seg_of(dvr[7:4]));
    check({tag, "_dig0"}, cap[0], seg_of(dvr[3:0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    buttons = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_led", led, 8'h80);
    check("rst_spr", dut.spr_reg, 7'h7F);
    check("rst_dvr", dut.dvr_reg, 8'h00);
    check("rst_anodes", {an3, an2, an1, an0}, 4'hF);
    check("rst_seg", seg, 7'h7F);

    press(4'b0001, 8'd69, "PUSH");
    press(4'b0001, 8'd42, "PUSH");
    press(4'b0001, 8'd25, "PUSH");
    expect_state("push3", 7'h7C, 8'h7D, 8'h19);
    check_display("disp1", 7'h7D, 8'h19);

    press(4'b0101, 8'h00, "ADD");
    expect_state("add", 7'h7D, 8'h7E, 8'h43);
    press(4'b0110, 8'h00, "SUB");
    expect_state("sub", 7'h7E, 8'h7F, 8'h02);

    press(4'b0001, 8'd3, "PUSH");
    press(4'b0001, 8'd5, "PUSH");
    press(4'b0110, 8'h00, "SUB");
    expect_state("subwrap", 7'h7D, 8'h7E, 8'hFE);
    check_display("disp2", 7'h7E, 8'hFE);

    press(4'b0010, 8'h00, "POP");
    expect_state("pop1", 7'h7E, 8'h7F, 8'h02);
    press(4'b0010, 8'h00, "POP");
    expect_state("pop2", 7'h7F, 8'h80, 8'h00);
    press(4'b0010, 8'h00, "POP");
    expect_state("pop_empty", 7'h7F, 8'h80, 8'h00);
    press(4'b1110, 8'h00, "DAR_DEC");
    expect_state("dar_dec_wrap", 7'h7F, 8'hFF, 8'h00);

    press(4'b0001, 8'd69, "PUSH");
    press(4'b0001, 8'd42, "PUSH");
    press(4'b0001, 8'd25, "PUSH");
    expect_state("repush", 7'h7C, 8'h7D, 8'h19);
    press(4'b1101, 8'h00, "DAR_INC");
    press(4'b1101, 8'h00, "DAR_INC");
    expect_state("dar_inc2", 7'h7C, 8'h7F, 8'h45);
    press(4'b1101, 8'h00, "DAR_INC");
    expect_state("dar_inc_wrap", 7'h7C, 8'h00, 8'h00);
    press(4'b1001, 8'h00, "DAR_TOP");
    expect_state("dar_top", 7'h7C, 8'h7D, 8'h19);
    press(4'b1110, 8'h00, "DAR_DEC");
    expect_state("dar_dec", 7'h7C, 8'h7C, 8'h00);
    press(4'b0011, 8'h00, "BOGUS");
    expect_state("ignored", 7'h7C, 8'h7C, 8'h00);
    press(4'b1010, 8'h00, "CLEAR");
    expect_state("clear", 7'h7F, 8'h80, 8'h00);

    for (int k = 1; k <= 127; k++) press(4'b0001, 8'(k), "PUSH");
    expect_state("full", 7'h00, 8'h01, 8'h7F);
    press(4'b0001, 8'hAA, "PUSH");
    expect_state("push_full", 7'h00, 8'h01, 8'h7F);
    press(4'b0101, 8'h00, "ADD");
    expect_state("add_full", 7'h01, 8'h02, 8'hFD);

    // Reset in the middle of a press: state and RAM return to reset values
    switch_val = 8'h55;
    buttons = 4'b0001;
    repeat (40) @(posedge clk);
    do_reset();
    expect_state("midrst", 7'h7F, 8'h80, 8'h00);
    press(4'b1101, 8'h00, "DAR_INC");
    press(4'b1101, 8'h00, "DAR_INC");
    expect_state("ram_wiped", 7'h7F, 8'h82, 8'h00);

`ifdef STACK_CALC_DEBOUNCE_EN
    switch_val = 8'h3C;
    for (int t = 0; t < 20; t++) begin
      buttons[0] = ~buttons[0];
      repeat (10) @(posedge clk);
    end
    buttons = 4'b0001;
    repeat (100) @(posedge clk);
    buttons = 4'h0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    $display("cmd %-8s code=0001 sw=0x3c led=0x%02h", "BOUNCE", led);
    expect_state("glitch", 7'h7E, 8'h7F, 8'h3C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
